// File: rtl/ebi_read_responder_if.sv
// EBI read-side pin bundle plus the register-fabric read port.
// The responder uses the slave view; the MCU/fabric model uses the master view.
interface ebi_read_responder_if;
    logic [15:0] EBI_AD_in;
    logic        EBI_ALE;
    logic        EBI_RE;
    logic        EBI_WE;
    logic [15:0] EBI_AD_out;
    logic        EBI_AD_oe;
    logic [15:0] rd_addr;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [7:0]  timeout_count;

    modport slave (
        input  EBI_AD_in, EBI_ALE, EBI_RE, EBI_WE, rd_data, rd_valid,
        output EBI_AD_out, EBI_AD_oe, rd_addr, rd_req, timeout_count
    );

    modport master (
        output EBI_AD_in, EBI_ALE, EBI_RE, EBI_WE, rd_data, rd_valid,
        input  EBI_AD_out, EBI_AD_oe, rd_addr, rd_req, timeout_count
    );
endinterface

// File: rtl/ebi_read_responder.sv
// Answers MCU EBI read cycles: latches address on ALE rise, fetches from fabric, drives data while RE low.
// Latency 3 clk from pin edges (2-FF sync + register); fabric stall bounded by TIMEOUT_CYCLES, then DEFAULT_DATA.
module ebi_read_responder #(
    parameter int          TIMEOUT_CYCLES = 15,
    parameter logic [15:0] DEFAULT_DATA   = 16'hDEAD
) (
    input  logic               clk,
    input  logic               reset,
    ebi_read_responder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_READY,
        S_DRIVE
    } state_t;

    state_t state, state_n;

    logic        ale_s1, ale_s2, ale_s3;
    logic        re_s1, re_s2;
    logic        we_s1, we_s2;
    logic [15:0] ad_p1, ad_p2;
    logic [TW-1:0] timer;
    logic        ale_end;
    logic        capture;
    logic        tmo;

    // Strobes idle high; AD is piped two deep so ad_p2 lines up with ale_s2.
    always_ff @(posedge clk) begin
        if (reset) begin
            ale_s1 <= 1'b1;
            ale_s2 <= 1'b1;
            ale_s3 <= 1'b1;
            re_s1  <= 1'b1;
            re_s2  <= 1'b1;
            we_s1  <= 1'b1;
            we_s2  <= 1'b1;
            ad_p1  <= '0;
            ad_p2  <= '0;
        end else begin
            ale_s1 <= bus.EBI_ALE;
            ale_s2 <= ale_s1;
            ale_s3 <= ale_s2;
            re_s1  <= bus.EBI_RE;
            re_s2  <= re_s1;
            we_s1  <= bus.EBI_WE;
            we_s2  <= we_s1;
            ad_p1  <= bus.EBI_AD_in;
            ad_p2  <= ad_p1;
        end
    end

    assign ale_end = ale_s2 & ~ale_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A new address phase preempts everything, including an active drive.
    always_comb begin
        state_n = state;
        capture = 1'b0;
        tmo     = 1'b0;
        if (ale_end) begin
            state_n = S_REQ;
        end else begin
            case (state)
                S_IDLE:  state_n = S_IDLE;
                S_REQ:   state_n = S_WAIT;
                S_WAIT: begin
                    if (bus.rd_valid) begin
                        capture = 1'b1;
                        state_n = re_s2 ? S_READY : S_DRIVE;
                    end else if (timer == TMO_LAST) begin
                        tmo     = 1'b1;
                        state_n = re_s2 ? S_READY : S_DRIVE;
                    end
                end
                S_READY: begin
                    if (!re_s2) begin
                        state_n = S_DRIVE;
                    end else if (!we_s2) begin
                        state_n = S_IDLE;
                    end
                end
                S_DRIVE: begin
                    if (re_s2) begin
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer             <= '0;
            bus.EBI_AD_out    <= '0;
            bus.EBI_AD_oe     <= 1'b0;
            bus.rd_addr       <= '0;
            bus.rd_req        <= 1'b0;
            bus.timeout_count <= '0;
        end else begin
            if (state == S_REQ) begin
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + TW'(1);
            end
            if (ale_end) begin
                bus.rd_addr <= ad_p2;
            end
            if (capture) begin
                bus.EBI_AD_out <= bus.rd_data;
            end else if (tmo) begin
                bus.EBI_AD_out <= DEFAULT_DATA;
            end
            if (tmo && bus.timeout_count != 8'hFF) begin
                bus.timeout_count <= bus.timeout_count + 8'd1;
            end
            bus.rd_req    <= (state_n == S_REQ);
            bus.EBI_AD_oe <= (state_n == S_DRIVE);
        end
    end
endmodule

// File: tb/tb_ebi_read_responder.sv
// Directed bench for ebi_read_responder: read, timeout/saturation, early RE, write cycle, re-address, reset.
module tb_ebi_read_responder;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   req_cnt = 0;
    int   oe_cnt = 0;

    ebi_read_responder_if bus();

    ebi_read_responder #(
        .TIMEOUT_CYCLES(15),
        .DEFAULT_DATA  (16'hDEAD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rd_req === 1'b1) req_cnt++;
        if (bus.EBI_AD_oe === 1'b1) oe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address phase: ALE low two clocks, then rise; returns just after the REQ edge.
    task automatic ale_cycle(input logic [15:0] addr);
        bus.EBI_AD_in = addr;
        bus.EBI_ALE   = 1'b0;
        tick(2);
        bus.EBI_ALE = 1'b1;
        tick(3);
        bus.EBI_AD_in = 16'h0000;
    endtask

    initial begin
        bus.EBI_AD_in = '0;
        bus.EBI_ALE   = 1'b1;
        bus.EBI_RE    = 1'b1;
        bus.EBI_WE    = 1'b1;
        bus.rd_data   = '0;
        bus.rd_valid  = 1'b0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_oe", 16'(bus.EBI_AD_oe), 16'h0);
        check("rst_out", bus.EBI_AD_out, 16'h0000);
        check("rst_addr", bus.rd_addr, 16'h0000);
        check("rst_req", 16'(bus.rd_req), 16'h0);
        check("rst_tcnt", 16'(bus.timeout_count), 16'h0);

        // Basic read, fabric answers two clocks after rd_req.
        req_cnt = 0;
        ale_cycle(16'h0012);
        check("rd_req_pulse", 16'(bus.rd_req), 16'h1);
        check("rd_addr_0012", bus.rd_addr, 16'h0012);
        tick(1);
        check("rd_req_one_cycle", 16'(bus.rd_req), 16'h0);
        tick(1);
        bus.rd_data  = 16'hBEEF;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        bus.rd_data  = 16'h0000;
        check("cap_beef", bus.EBI_AD_out, 16'hBEEF);
        check("oe_before_re", 16'(bus.EBI_AD_oe), 16'h0);
        bus.EBI_RE = 1'b0;
        tick(2);
        check("oe_re_2clk", 16'(bus.EBI_AD_oe), 16'h0);
        tick(1);
        check("oe_re_3clk", 16'(bus.EBI_AD_oe), 16'h1);
        tick(5);
        check("drive_beef", bus.EBI_AD_out, 16'hBEEF);
        check("oe_hold", 16'(bus.EBI_AD_oe), 16'h1);
        bus.EBI_RE = 1'b1;
        tick(2);
        check("oe_rise_2clk", 16'(bus.EBI_AD_oe), 16'h1);
        tick(1);
        check("oe_rise_3clk", 16'(bus.EBI_AD_oe), 16'h0);
        check("req_count", 16'(req_cnt), 16'h1);

        // Fabric never answers: default data and timeout count.
        ale_cycle(16'h0100);
        tick(20);
        check("tmo_cnt1", 16'(bus.timeout_count), 16'h1);
        check("tmo_data", bus.EBI_AD_out, 16'hDEAD);
        check("tmo_oe_idle", 16'(bus.EBI_AD_oe), 16'h0);
        bus.EBI_RE = 1'b0;
        tick(3);
        check("tmo_drive_oe", 16'(bus.EBI_AD_oe), 16'h1);
        check("tmo_drive_dat", bus.EBI_AD_out, 16'hDEAD);
        bus.EBI_RE = 1'b1;
        tick(3);
        check("tmo_release", 16'(bus.EBI_AD_oe), 16'h0);

        for (int i = 1; i < 300; i++) begin
            ale_cycle(16'h0100);
            tick(18);
            if (i == 253) check("tmo_cnt_fe", 16'(bus.timeout_count), 16'h00FE);
            if (i == 254) check("tmo_cnt_ff", 16'(bus.timeout_count), 16'h00FF);
        end
        check("tmo_saturated", 16'(bus.timeout_count), 16'h00FF);

        // RE falls before data arrives; fabric latency six clocks.
        ale_cycle(16'h0200);
        bus.EBI_RE = 1'b0;
        tick(6);
        check("early_re_oe0", 16'(bus.EBI_AD_oe), 16'h0);
        bus.rd_data  = 16'h1234;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        check("early_re_oe1", 16'(bus.EBI_AD_oe), 16'h1);
        check("early_re_dat", bus.EBI_AD_out, 16'h1234);
        tick(3);
        bus.EBI_RE = 1'b1;
        tick(2);
        check("early_re_hold", 16'(bus.EBI_AD_oe), 16'h1);
        tick(1);
        check("early_re_rel", 16'(bus.EBI_AD_oe), 16'h0);

        // Write cycle: request still issued, nothing ever driven.
        oe_cnt = 0;
        ale_cycle(16'h0300);
        check("wr_req", 16'(bus.rd_req), 16'h1);
        check("wr_addr", bus.rd_addr, 16'h0300);
        bus.EBI_WE = 1'b0;
        tick(2);
        bus.rd_data  = 16'h5555;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        tick(6);
        bus.EBI_WE = 1'b1;
        tick(3);
        bus.EBI_RE = 1'b0;
        tick(6);
        bus.EBI_RE = 1'b1;
        tick(3);
        check("wr_no_oe", 16'(oe_cnt), 16'h0);

        // Second ALE during DRIVE; stale rd_valid in REQ must be ignored.
        ale_cycle(16'h0010);
        tick(1);
        bus.rd_data  = 16'hAAAA;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        bus.EBI_RE = 1'b0;
        tick(4);
        check("pre_realе_oe", 16'(bus.EBI_AD_oe), 16'h1);
        bus.EBI_AD_in = 16'h0040;
        bus.EBI_ALE   = 1'b0;
        tick(2);
        bus.EBI_ALE = 1'b1;
        tick(2);
        check("realе_oe_still", 16'(bus.EBI_AD_oe), 16'h1);
        tick(1);
        bus.EBI_AD_in = 16'h0000;
        check("realе_oe_drop", 16'(bus.EBI_AD_oe), 16'h0);
        check("realе_req", 16'(bus.rd_req), 16'h1);
        check("realе_addr", bus.rd_addr, 16'h0040);
        bus.rd_data  = 16'h0BAD;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        check("stale_ignored", bus.EBI_AD_out, 16'hAAAA);
        tick(1);
        bus.rd_data  = 16'h4040;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        check("realе_drive_oe", 16'(bus.EBI_AD_oe), 16'h1);
        check("realе_drive_dat", bus.EBI_AD_out, 16'h4040);

        // Reset while driving.
        reset = 1'b1;
        tick(1);
        check("mid_rst_oe", 16'(bus.EBI_AD_oe), 16'h0);
        check("mid_rst_out", bus.EBI_AD_out, 16'h0000);
        check("mid_rst_addr", bus.rd_addr, 16'h0000);
        check("mid_rst_req", 16'(bus.rd_req), 16'h0);
        check("mid_rst_tcnt", 16'(bus.timeout_count), 16'h0);
        reset = 1'b0;
        bus.EBI_RE = 1'b1;
        tick(5);
        check("post_rst_oe", 16'(bus.EBI_AD_oe), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
